pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_sat_counter.sv | 32 +++
 rtl/pipe_skid_stage.sv | 134 +++++++++++++
 tb/tb_pipe_skid_stage.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline skid stage: state encoding
// and the bit positions inside the control bundle.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    localparam int CTRL_MEMTOREG = 0;
    localparam int CTRL_REGWRITE = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_EXTOP    = 3;

    // A beat sits in the main register whenever the stage is not empty.
    function automatic logic state_has_beat(input pipe_state_e s);
        return (s != EMPTY);
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// W-bit counter that increments on inc_i and sticks at all-ones.
// Only a synchronous active-low reset clears it.
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry pipeline register with a skid slot, flush, and a state-decoded ready.
// Define PIPE_PERF_CNT_EN to add the saturating backpressure counter (stall_cnt_o).
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o,
    input  logic              flush_i
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o
`endif
);

    pipe_state_e       state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              accept;
    logic              send;

    // Ready depends only on state, so out_ready_i never reaches in_ready_o.
    assign in_ready_o  = (state_q != FULL);
    assign out_valid_o = state_has_beat(state_q);
    assign accept      = in_valid_i && in_ready_o;
    assign send        = out_valid_o && out_ready_i;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        data_d      = data_q;
        ctrl_d      = ctrl_q;
        skid_pc_d   = skid_pc_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush_i) begin
            // Kill everything, including a beat offered this same cycle.
            state_d = EMPTY;
            ctrl_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        pc_d    = pc_i;
                        data_d  = data_i;
                        ctrl_d  = ctrl_i;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && send) begin
                        pc_d   = pc_i;
                        data_d = data_i;
                        ctrl_d = ctrl_i;
                    end else if (send) begin
                        state_d = EMPTY;
                    end else if (accept) begin
                        skid_pc_d   = pc_i;
                        skid_data_d = data_i;
                        skid_ctrl_d = ctrl_i;
                        state_d     = FULL;
                    end
                end
                FULL: begin
                    if (send) begin
                        pc_d    = skid_pc_q;
                        data_d  = skid_data_q;
                        ctrl_d  = skid_ctrl_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= EMPTY;
            pc_q        <= '0;
            data_q      <= '0;
            ctrl_q      <= '0;
            skid_pc_q   <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            data_q      <= data_d;
            ctrl_q      <= ctrl_d;
            skid_pc_q   <= skid_pc_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    assign pc_o   = pc_q;
    assign data_o = data_q;
    // An empty stage always presents a bubble on the control lines.
    assign ctrl_o = out_valid_o ? ctrl_q : '0;

`ifdef PIPE_PERF_CNT_EN
    pipe_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (out_valid_o && !out_ready_i),
        .cnt_o (stall_cnt_o)
    );
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed self-checking bench for pipe_skid_stage; counter checks run when
// PIPE_PERF_CNT_EN is defined.
module tb_pipe_skid_stage;
    import pipe_pkg::*;

    localparam int PC_W   = 32;
    localparam int DATA_W = 32;
    localparam int CTRL_W = 4;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   pc_in;
    logic [DATA_W-1:0] data_in;
    logic [CTRL_W-1:0] ctrl_in;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   pc_out;
    logic [DATA_W-1:0] data_out;
    logic [CTRL_W-1:0] ctrl_out;
    logic              flush;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
`endif

    int vectors;
    int miscompares;

    pipe_skid_stage #(
        .PC_W   (PC_W),
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .pc_i        (pc_in),
        .data_i      (data_in),
        .ctrl_i      (ctrl_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .pc_o        (pc_out),
        .data_o      (data_out),
        .ctrl_o      (ctrl_out),
        .flush_i     (flush)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] d,
                         input logic [3:0] c);
        in_valid = v;
        pc_in    = pc;
        data_in  = d;
        ctrl_in  = c;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b1; out_ready = 1'b0;
        drive(1'b1, 32'h55, 32'h66, 4'hA);
        step();
        step();
        rst = 1'b1; flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end else $display("reset_handshake ok");
        vectors++;
        if (pc_out !== 32'h0 || data_out !== 32'h0 || ctrl_out !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_payload: pc=%h data=%h ctrl=%h, required all zero", pc_out, data_out, ctrl_out);
        end else $display("reset_payload ok");
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        step();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        vectors++;
        if (out_valid !== 1'b1 || pc_out !== 32'h100 || data_out !== 32'hDEADBEEF
            || ctrl_out !== 4'hF || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_beat: v=%b pc=%h data=%h ctrl=%h rdy=%b, required 1/100/deadbeef/f/1",
                     out_valid, pc_out, data_out, ctrl_out, in_ready);
        end else $display("single_beat ok");
        step();
        vectors++;
        if (out_valid !== 1'b0 || ctrl_out !== 4'h0) begin
            miscompares++;
            $display("FAIL single_drain: v=%b ctrl=%h, required 0/0", out_valid, ctrl_out);
        end else $display("single_drain ok");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 32'h1, 32'h1, 4'h1);
        step();
        drive(1'b1, 32'h2, 32'h2, 4'h2);
        step();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || data_out !== 32'h1 || ctrl_out !== 4'h1) begin
            miscompares++;
            $display("FAIL bp_full: rdy=%b v=%b data=%h ctrl=%h, required 0/1/1/1",
                     in_ready, out_valid, data_out, ctrl_out);
        end else $display("bp_full ok");
        step();
        vectors++;
        if (pc_out !== 32'h1 || data_out !== 32'h1 || ctrl_out !== 4'h1) begin
            miscompares++;
            $display("FAIL bp_hold: pc=%h data=%h ctrl=%h, required 1/1/1", pc_out, data_out, ctrl_out);
        end else $display("bp_hold ok");
        out_ready = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b1 || data_out !== 32'h2 || pc_out !== 32'h2 || ctrl_out !== 4'h2
            || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_second: v=%b pc=%h data=%h ctrl=%h rdy=%b, required 1/2/2/2/1",
                     out_valid, pc_out, data_out, ctrl_out, in_ready);
        end else $display("bp_second ok");
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_drain: v=%b, required 0", out_valid);
        end else $display("bp_drain ok");
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'h11, 32'hA1, 4'h5);
        step();
        drive(1'b1, 32'h22, 32'hB2, 4'h6);
        step();
        drive(1'b1, 32'h33, 32'hC3, 4'h7);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        vectors++;
        if (out_valid !== 1'b0 || ctrl_out !== 4'h0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_full: v=%b ctrl=%h rdy=%b, required 0/0/1", out_valid, ctrl_out, in_ready);
        end else $display("flush_full ok");
        vectors++;
        if (pc_out !== 32'h11 || data_out !== 32'hA1) begin
            miscompares++;
            $display("FAIL flush_hold: pc=%h data=%h, required 11/a1", pc_out, data_out);
        end else $display("flush_hold ok");
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_no_emit[%0d]: v=%b data=%h, required v=0", i, out_valid, data_out);
            end else $display("flush_no_emit[%0d] ok", i);
        end
        // Flush on the same edge as an accept into an empty stage drops that beat.
        drive(1'b1, 32'h44, 32'hD4, 4'h9);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        vectors++;
        if (out_valid !== 1'b0 || ctrl_out !== 4'h0) begin
            miscompares++;
            $display("FAIL flush_priority: v=%b ctrl=%h, required 0/0", out_valid, ctrl_out);
        end else $display("flush_priority ok");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 32'h1000 + i, i, 4'(i));
            step();
            vectors++;
            if (out_valid !== 1'b1 || data_out !== 32'(i) || pc_out !== 32'h1000 + i
                || ctrl_out !== 4'(i) || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b[%0d]: v=%b data=%h ctrl=%h rdy=%b, required 1/%h/%h/1",
                         i, out_valid, data_out, ctrl_out, in_ready, i, 4'(i));
            end else $display("b2b[%0d] ok data=%h", i, data_out);
        end
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: v=%b, required 0", out_valid);
        end else $display("b2b_drain ok");
    endtask

`ifdef PIPE_PERF_CNT_EN
    task automatic test_stall_cnt();
        rst = 1'b0;
        step();
        rst = 1'b1;
        vectors++;
        if (stall_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL cnt_reset: cnt=%0d, required 0", stall_cnt);
        end else $display("cnt_reset ok");
        out_ready = 1'b0;
        drive(1'b1, 32'h7, 32'h7, 4'h7);
        step();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) step();
        vectors++;
        if (stall_cnt !== 4'd5) begin
            miscompares++;
            $display("FAIL cnt_partial: cnt=%0d, required 5", stall_cnt);
        end else $display("cnt_partial ok");
        for (int i = 0; i < 15; i++) step();
        vectors++;
        if (stall_cnt !== 4'd15) begin
            miscompares++;
            $display("FAIL cnt_saturate: cnt=%0d, required 15", stall_cnt);
        end else $display("cnt_saturate ok");
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        vectors++;
        if (stall_cnt !== 4'd15) begin
            miscompares++;
            $display("FAIL cnt_flush: cnt=%0d, required 15", stall_cnt);
        end else $display("cnt_flush ok");
        rst = 1'b0;
        step();
        rst = 1'b1;
        vectors++;
        if (stall_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL cnt_rereset: cnt=%0d, required 0", stall_cnt);
        end else $display("cnt_rereset ok");
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        test_reset();
        test_single();
        test_backpressure();
        test_flush();
        test_back_to_back();
`ifdef PIPE_PERF_CNT_EN
        test_stall_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
